// File: rtl/frame_write_scheduler.sv
// Frame-aligned write-port arbiter for the frame buffer: picks raw or binarized pixels per frame
// and implements a one-frame capture followed by a freeze of all RAM writes.
module frame_write_scheduler #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 12,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              mode_bin,
  input  logic              freeze_req,
  input  logic              src0_ena,
  input  logic [ADDR_W-1:0] src0_addr,
  input  logic [DATA_W-1:0] src0_data,
  input  logic              src1_ena,
  input  logic [ADDR_W-1:0] src1_addr,
  input  logic [DATA_W-1:0] src1_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              active_src,
  output logic              frozen,
  output logic              frame_done,
  output logic [ADDR_W-1:0] pix_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STREAM  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_FROZEN  = 3'd3,
    ST_RESYNC  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   FRAME_LIMIT = (ADDR_W+1)'(FRAME_PIXELS);
  localparam logic [ADDR_W-1:0] CNT_MAX     = {ADDR_W{1'b1}};

  state_t              state_q, state_d;
  logic                vsync_q;
  logic                freeze_pend_q, freeze_pend_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                active_src_q, active_src_d;
  logic                frozen_q, frozen_d;
  logic                frame_done_q, frame_done_d;
  logic [ADDR_W-1:0]   pix_cnt_q, pix_cnt_d;

  logic                fe_s;
  logic                src_s;
  logic                sel_ena_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic                wr_state_s;
  logic                wr_s;

  function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] val, input logic inc);
    if (inc && (val != CNT_MAX)) begin
      sat_inc = val + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      sat_inc = val;
    end
  endfunction

  // Source selection and write qualification; the fe cycle already uses the new source.
  always_comb begin
    fe_s       = vsync & ~vsync_q;
    src_s      = fe_s ? mode_bin : active_src_q;
    sel_ena_s  = src_s ? src1_ena  : src0_ena;
    sel_addr_s = src_s ? src1_addr : src0_addr;
    sel_data_s = src_s ? src1_data : src0_data;
    wr_state_s = (state_q == ST_STREAM) || (state_q == ST_CAPTURE);
    wr_s       = wr_state_s && sel_ena_s && ({1'b0, sel_addr_s} < FRAME_LIMIT);
  end

  // Next-state computation for the FSM, write path and frame counters.
  always_comb begin
    state_d       = state_q;
    freeze_pend_d = freeze_pend_q;
    cnt_d         = cnt_q;
    pix_cnt_d     = pix_cnt_q;
    frame_done_d  = 1'b0;
    active_src_d  = src_s;
    ram_we_d      = wr_s;
    ram_addr_d    = ram_addr_q;
    ram_din_d     = ram_din_q;

    if (wr_s) begin
      ram_addr_d = sel_addr_s;
      ram_din_d  = sel_data_s;
    end else begin
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
    end

    // A pixel written in the fe cycle counts toward both the closing and the new frame.
    if (wr_state_s) begin
      if (fe_s) begin
        pix_cnt_d    = sat_inc(cnt_q, wr_s);
        cnt_d        = {{(ADDR_W-1){1'b0}}, wr_s};
        frame_done_d = 1'b1;
      end else begin
        cnt_d = sat_inc(cnt_q, wr_s);
      end
    end else begin
      cnt_d = {ADDR_W{1'b0}};
    end

    case (state_q)
      ST_IDLE: begin
        if (fe_s) begin
          state_d = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (fe_s) begin
          if (freeze_pend_q || freeze_req) begin
            state_d       = ST_CAPTURE;
            freeze_pend_d = 1'b0;
          end else begin
            state_d = ST_STREAM;
          end
        end else if (freeze_req) begin
          freeze_pend_d = 1'b1;
        end else begin
          freeze_pend_d = freeze_pend_q;
        end
      end
      ST_CAPTURE: begin
        if (fe_s) begin
          state_d = ST_FROZEN;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_FROZEN: begin
        if (freeze_req) begin
          state_d = ST_RESYNC;
        end else begin
          state_d = ST_FROZEN;
        end
      end
      ST_RESYNC: begin
        if (fe_s) begin
          state_d = ST_STREAM;
        end else begin
          state_d = ST_RESYNC;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        freeze_pend_d = 1'b0;
      end
    endcase

    frozen_d = (state_d == ST_FROZEN);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      vsync_q       <= 1'b0;
      freeze_pend_q <= 1'b0;
      cnt_q         <= {ADDR_W{1'b0}};
      ram_we_q      <= 1'b0;
      ram_addr_q    <= {ADDR_W{1'b0}};
      ram_din_q     <= {DATA_W{1'b0}};
      active_src_q  <= 1'b0;
      frozen_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      pix_cnt_q     <= {ADDR_W{1'b0}};
    end else begin
      state_q       <= state_d;
      vsync_q       <= vsync;
      freeze_pend_q <= freeze_pend_d;
      cnt_q         <= cnt_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      active_src_q  <= active_src_d;
      frozen_q      <= frozen_d;
      frame_done_q  <= frame_done_d;
      pix_cnt_q     <= pix_cnt_d;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign active_src = active_src_q;
  assign frozen     = frozen_q;
  assign frame_done = frame_done_q;
  assign pix_cnt    = pix_cnt_q;

endmodule

// File: tb/tb_frame_write_scheduler.sv
// Scoreboard bench for frame_write_scheduler using a reduced 64-pixel frame.
module tb_frame_write_scheduler;
  localparam int AW = 19;
  localparam int DW = 12;
  localparam int FP = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          vsync = 1'b0;
  logic          mode_bin = 1'b0;
  logic          freeze_req = 1'b0;
  logic          src0_ena = 1'b0;
  logic [AW-1:0] src0_addr = '0;
  logic [DW-1:0] src0_data = '0;
  logic          src1_ena = 1'b0;
  logic [AW-1:0] src1_addr = '0;
  logic [DW-1:0] src1_data = '0;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          active_src;
  logic          frozen;
  logic          frame_done;
  logic [AW-1:0] pix_cnt;

  int ntests = 0;
  int nfail  = 0;
  logic [AW+DW-1:0] exp_wr[$];
  logic [AW-1:0]    exp_fd[$];

  frame_write_scheduler #(.ADDR_W(AW), .DATA_W(DW), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .mode_bin(mode_bin), .freeze_req(freeze_req),
    .src0_ena(src0_ena), .src0_addr(src0_addr), .src0_data(src0_data),
    .src1_ena(src1_ena), .src1_addr(src1_addr), .src1_data(src1_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .active_src(active_src),
    .frozen(frozen), .frame_done(frame_done), .pix_cnt(pix_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write and every frame_done pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (ram_we) begin
        ntests++;
        if (exp_wr.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", ram_addr, ram_din);
        end else begin
          logic [AW+DW-1:0] e;
          e = exp_wr.pop_front();
          if ({ram_addr, ram_din} !== e) begin
            nfail++;
            $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                     ram_addr, ram_din, e[AW+DW-1:DW], e[DW-1:0]);
          end
        end
      end
      if (frame_done) begin
        ntests++;
        if (exp_fd.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_frame_done: got pix_cnt %0d expected no pulse", pix_cnt);
        end else begin
          logic [AW-1:0] f;
          f = exp_fd.pop_front();
          if (pix_cnt !== f) begin
            nfail++;
            $display("FAIL pix_cnt: got %0d expected %0d", pix_cnt, f);
          end
        end
      end
    end
  end

  // One clock of stimulus; both sources carry the same address but distinct data.
  task automatic tick(input bit vs, input bit frz, input bit en, input int addr,
                      input int idx, input bit expw, input bit esrc);
    vsync      = vs;
    freeze_req = frz;
    src0_ena   = en;
    src1_ena   = en;
    src0_addr  = AW'(addr);
    src1_addr  = AW'(addr);
    src0_data  = DW'(12'h100 + idx);
    src1_data  = DW'(12'h800 + idx);
    if (expw) exp_wr.push_back({AW'(addr), esrc ? DW'(12'h800 + idx) : DW'(12'h100 + idx)});
    @(posedge clk);
    #1;
    vsync      = 1'b0;
    freeze_req = 1'b0;
    src0_ena   = 1'b0;
    src1_ena   = 1'b0;
  endtask

  task automatic frame(input bit mode, input bit frz_fe, input bit fe_pix, input bit fe_w,
                       input int n, input bit expw, input bit fd, input int fd_cnt);
    mode_bin = mode;
    if (fd) exp_fd.push_back(AW'(fd_cnt));
    tick(1'b1, frz_fe, fe_pix, 50, 50, fe_w, mode);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1, i, i, expw, mode);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_din"}, 32'(ram_din), 32'd0);
    check({tag, "_active_src"}, 32'(active_src), 32'd0);
    check({tag, "_frozen"}, 32'(frozen), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_pix_cnt"}, 32'(pix_cnt), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    // Pixels before any frame edge are not written.
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, i, i, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0, 0);
    check("t1_active_src", 32'(active_src), 32'd0);

    // Mid-frame mode change waits for the next edge.
    frame(1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b1, 10);
    mode_bin = 1'b1;
    for (int i = 4; i < 8; i++) tick(1'b0, 1'b0, 1'b1, i, i, 1'b1, 1'b0);
    check("t2_active_src_mid", 32'(active_src), 32'd0);
    frame(1'b1, 1'b0, 1'b1, 1'b1, 6, 1'b1, 1'b1, 9);
    check("t2_active_src_new", 32'(active_src), 32'd1);

    // Full frame plus out-of-range addresses.
    frame(1'b1, 1'b0, 1'b0, 1'b0, FP, 1'b1, 1'b1, 7);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, FP + i, FP + i, 1'b0, 1'b1);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b1, FP);

    // Mid-frame freeze request: capture next frame, then freeze.
    tick(1'b0, 1'b1, 1'b1, 3, 3, 1'b1, 1'b0);
    for (int i = 4; i < 6; i++) tick(1'b0, 1'b0, 1'b1, i, i, 1'b1, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b1, 6);
    check("t4_capture_not_frozen", 32'(frozen), 32'd0);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b1, 5);
    check("t4_frozen_g", 32'(frozen), 32'd1);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 0);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 0);
    check("t4_frozen_i", 32'(frozen), 32'd1);
    tick(1'b0, 1'b1, 1'b1, 7, 7, 1'b0, 1'b0);
    check("t4_resync_unfrozen", 32'(frozen), 32'd0);
    for (int i = 8; i < 10; i++) tick(1'b0, 1'b0, 1'b1, i, i, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0, 0);

    // Freeze request coincident with the edge: capture starts there, edge pixel written.
    frame(1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b1, 5);
    check("t5_capture_not_frozen", 32'(frozen), 32'd0);
    check("t5_active_src", 32'(active_src), 32'd1);

    // Reset pulse in the middle of CAPTURE.
    tick(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    mode_bin = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, i, i, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0, 0);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    check("leftover_writes", 32'(exp_wr.size()), 32'd0);
    check("leftover_frame_done", 32'(exp_fd.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
